instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues reads to instruction memory, and presents the fetched word to decode.
//  Outputs if_instr and opcode (= if_instr[31:26]); opcode drives the main control decoder.
//  Handles PC redirects from branch and jump resolution, downstream stalls, and variable-latency imem responses.
//  Holds at most one imem request outstanding.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
// PORTS
//  clk            in   1   single clock; all state updates on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  imem_req       out  1   read request; level; held until imem_rvalid
//  imem_addr      out  32  word address of request; stable while imem_req=1
//  imem_rvalid    in   1   response valid; may assert in the same cycle as imem_req
//  imem_rdata     in   32  instruction word; valid when imem_rvalid=1
//  stall          in   1   decode cannot accept; hold IF/ID contents
//  branch_taken   in   1   taken-branch redirect (1-cycle pulse)
//  branch_target  in   32  branch destination
//  jump           in   1   jump redirect (1-cycle pulse)
//  jump_target    in   32  jump destination
//  if_valid       out  1   IF/ID register holds a valid instruction
//  if_instr       out  32  fetched instruction
//  if_pc          out  32  address of if_instr
//  if_pc_plus4    out  32  if_pc + 4
//  opcode         out  6   if_instr[31:26]
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC.
//   - if_valid=0; if_instr, if_pc, if_pc_plus4, opcode = 0; skid buffer empty.
//  States:
//   - IDLE: first cycle after reset release; go FETCH.
//   - FETCH: imem_req=1, imem_addr=pc.
//   - HOLD: response buffered in skid register; imem_req=0.
//   - DRAIN: discard one stale in-flight response; imem_req=1 with the old address.
//  FETCH transitions:
//   - rvalid & (!stall | !if_valid): load IF/ID {instr, pc, pc+4}, set if_valid=1, pc<=pc+4, stay in FETCH (back-to-back).
//   - rvalid & stall & if_valid: store the word in the skid buffer, go HOLD.
//  HOLD: when stall=0, move skid contents to IF/ID, pc<=pc+4, go FETCH.
//  Stall:
//   - IF/ID outputs do not change while stall=1 and if_valid=1.
//   - A bubble (if_valid=0) never blocks a fetch.
//  Redirect (jump | branch_taken):
//   - Highest priority; overrides stall.
//   - jump wins if both are asserted.
//   - Next cycle: pc=target, if_valid=0, skid buffer cleared.
//   - If a request is outstanding with no rvalid this cycle: go DRAIN, then FETCH at the target once the stale rvalid arrives.
//   - If rvalid arrives in the same cycle as the redirect: discard the data and go FETCH at the target.
//  Arithmetic and addressing:
//   - PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0x0.
//   - pc[1:0] is forced to 2'b00; target low bits are ignored.
//  Latency:
//   - With zero-wait imem and no stall: one instruction per cycle.
//   - IF/ID is updated on the edge at which rvalid is sampled.
// TESTING
//  1. Reset then release, zero-wait imem -> imem_addr 0x0,0x4,0x8 on successive cycles; if_pc follows one cycle behind; if_valid=1 from the 2nd edge.
//  2. Stall for 3 cycles while if_pc=0x4 -> if_instr and if_pc hold; imem_req drops in HOLD; after release if_pc=0x8 with no lost or duplicated word.
//  3. branch_taken=1, branch_target=0x40 during a stall -> next cycle if_valid=0 and imem_addr=0x40; following word has if_pc=0x40.
//  4. 3-cycle imem latency; jump to 0x100 one cycle after request to 0x10 -> DRAIN; response for 0x10 discarded; next request addr 0x100.
//  5. jump=1 (0x200) and branch_taken=1 (0x80) in the same cycle -> fetch resumes at 0x200.
//  6. rst_n asserted mid-request and in HOLD -> all outputs return to reset values immediately; refetch starts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read channel between the fetch unit and imem.
// The fetch unit holds imem_req/imem_addr until imem_rvalid; rvalid may arrive in the request cycle.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from imem and fills the IF/ID register for decode.
// One request in flight; a skid register absorbs a response that lands while decode stalls.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_target_i,
    input  logic               jump_i,
    input  logic [31:0]        jump_target_i,
    output logic               if_valid_o,
    output logic [31:0]        if_instr_o,
    output logic [31:0]        if_pc_o,
    output logic [31:0]        if_pc_plus4_o,
    output logic [5:0]         opcode_o
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, drain_addr_q, drain_addr_d, skid_q, skid_d;
    logic [31:0] instr_q, instr_d, if_pc_q, if_pc_d, if_pc4_q, if_pc4_d;
    logic        valid_q, valid_d, req, redirect;
    logic [31:0] target;

    assign redirect       = jump_i | branch_taken_i;
    assign target         = (jump_i ? jump_target_i : branch_target_i) & PC_MASK;
    assign req            = (state_q == FETCH) || (state_q == DRAIN);
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        skid_d       = skid_q;
        instr_d      = instr_q;
        if_pc_d      = if_pc_q;
        if_pc4_d     = if_pc4_q;
        valid_d      = valid_q;
        if (redirect) begin
            // An unanswered request must still be drained at its original address.
            pc_d    = target;
            valid_d = 1'b0;
            skid_d  = '0;
            state_d = (req && !imem.imem_rvalid) ? DRAIN : FETCH;
            if (state_q == FETCH) drain_addr_d = pc_q;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem.imem_rvalid && (!stall_i || !valid_q)) begin
                        instr_d  = imem.imem_rdata;
                        if_pc_d  = pc_q;
                        if_pc4_d = pc_q + 32'd4;
                        pc_d     = pc_q + 32'd4;
                        valid_d  = 1'b1;
                    end else if (imem.imem_rvalid) begin
                        skid_d  = imem.imem_rdata;
                        state_d = HOLD;
                    end else if (!stall_i) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_d  = skid_q;
                        if_pc_d  = pc_q;
                        if_pc4_d = pc_q + 32'd4;
                        pc_d     = pc_q + 32'd4;
                        valid_d  = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DRAIN: state_d = imem.imem_rvalid ? FETCH : DRAIN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC & PC_MASK;
            drain_addr_q <= '0;
            skid_q       <= '0;
            instr_q      <= '0;
            if_pc_q      <= '0;
            if_pc4_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_q       <= skid_d;
            instr_q      <= instr_d;
            if_pc_q      <= if_pc_d;
            if_pc4_q     <= if_pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign if_valid_o    = valid_q;
    assign if_instr_o    = instr_q;
    assign if_pc_o       = if_pc_q;
    assign if_pc_plus4_o = if_pc4_q;
    assign opcode_o      = instr_q[31:26];
endmodule
